io_handshake: RTL and testbench
===============================

# io_handshake

Sequential I/O handshake unit between the single-cycle datapath's control decoder and the board's switches, confirm button and display. It produces the `flag` the control decoder turns into `halt` during `in`/`out` instructions. It holds the processor until the operator presses a debounced confirm button, then releases exactly one cycle so the instruction commits. It also captures switch input for `in` and latches the display value for `out`.

## Interface
Parameters:
- `DATA_W`, 32: datapath word width.
- `SW_W`, 18: switch bank width; must be ≤ `DATA_W`.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles needed to accept a button level change (10 ms at 50 MHz).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock; all state on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_req`  in  1  decoder `MO`; an `in` instruction is current.
- `out_req`  in  1  decoder `out`; an `out` instruction is current.
- `sw`  in  SW_W  raw switch bank; sampled only at confirm.
- `btn`  in  1  raw confirm button, asynchronous, active-high.
- `out_data`  in  DATA_W  register value to display on `out`.
- `flag`  out  1  1 = processor must stall; feeds the decoder `flag`.
- `in_data`  out  DATA_W  zero-extended captured switches; write-back source for `in`.
- `disp_data`  out  DATA_W  latched display value.
- `disp_valid`  out  1  1 once any `out` has latched a value.

## Operation
- Button path:
  - 2-FF synchronizer, then a debouncer.
  - The counter increments while the synchronized level differs from `btn_stable`. It clears whenever the two are equal.
  - When the count reaches `DEBOUNCE_CYCLES - 1` and the level still differs, `btn_stable` toggles and the counter clears.
  - `press` = one-cycle pulse on each 0→1 transition of `btn_stable`.
- FSM states: IDLE, WAIT_IN, WAIT_OUT, RELEASE.
  - IDLE, `in_req` → WAIT_IN. `in_req` has priority if both requests are high.
  - IDLE, `out_req` (and no `in_req`) → WAIT_OUT. On this edge `disp_data` ← `out_data` and `disp_valid` ← 1.
  - WAIT_IN, `press` → RELEASE. On this edge `in_data` ← {zeros, `sw`}.
  - WAIT_OUT, `press` → RELEASE.
  - WAIT_x with its request deasserted → IDLE, nothing captured.
  - RELEASE → IDLE unconditionally.
- `flag` (combinational):
  - 1 in IDLE while `in_req | out_req`.
  - 1 in WAIT_IN and WAIT_OUT.
  - 0 in RELEASE.
  - 0 otherwise.
- `press` while in IDLE or RELEASE is discarded; it is never queued.
- Back-to-back I/O instructions: the following instruction is seen in IDLE the cycle after RELEASE and stalls again.
- `disp_data` is held until the next `out`; `in_data` is held until the next `in` capture.

## Timing
- Reset values:
  - state IDLE.
  - `in_data`, `disp_data` = 0; `disp_valid` = 0.
  - synchronizer FFs, `btn_stable` and the debounce counter = 0.
  - `flag` then depends only on `in_req`/`out_req`.
- Stall begins combinationally in the same cycle the request appears, so the PC never advances past an unconfirmed I/O instruction.
- Button latency, raw edge to `press`: 2 synchronizer cycles + `DEBOUNCE_CYCLES` + 1.
- `press` → RELEASE on the next edge. RELEASE lasts exactly 1 cycle with `flag` = 0; the register-file write for `in` occurs at the end of it.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles produce no `press`.
- A button held across multiple instructions produces one `press` only; release and re-press is required.
- Reset mid-WAIT or mid-RELEASE → IDLE immediately. No capture occurs, and already-latched data returns to 0.
- Debounce counter width is $clog2(`DEBOUNCE_CYCLES`) + 1 and must not wrap.

## Structure
- Shared package `io_pkg`:
  - FSM state enum (2 bits).
  - `SW_W`/`DATA_W` defaults.
- Sub-module `btn_debounce` (`clk`, `rst`, `btn`, output `press`, parameter `DEBOUNCE_CYCLES`) contains the synchronizer, debouncer and edge detector.
- `io_handshake` contains the FSM and the capture registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- Reset, then `in_req`=1, `sw`=18'h2A5A5, then a clean `btn` press → `flag`=1 from cycle 0 until `press`, then RELEASE with `flag`=0 for 1 cycle and `in_data`=32'h0002A5A5.
- `out_req`=1, `out_data`=32'hDEADBEEF → `disp_data`=32'hDEADBEEF and `disp_valid`=1 one edge later. `flag` stays 1 until `press`, then 0 for one cycle; `disp_data` holds after `out_req` drops.
- `btn` glitches of 1–3 cycles during WAIT_IN → no `press` and `flag` stays 1. A 6-cycle press → exactly one RELEASE.
- Button held high across two consecutive `in` instructions → the first completes and the second stalls until release and re-press. `in_data` updates to the second `sw` value.
- `in_req` and `out_req` both 1 in IDLE → WAIT_IN entered and `disp_data` unchanged.
- Assert `rst` during WAIT_OUT → state IDLE, `disp_data`=0, `disp_valid`=0, `flag` = `in_req | out_req` combinationally.

Source files
------------

// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_pkg
// Brief    : Shared types and defaults for the I/O handshake unit.
// Revision : 1.0 - initial release
// ============================================================================
package io_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int SW_W_DEFAULT   = 18;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_IN  = 2'd1,
        ST_WAIT_OUT = 2'd2,
        ST_RELEASE  = 2'd3
    } io_state_t;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Brief    : Button synchronizer, debouncer and rising-edge press pulse.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int              CNT_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_stable_d;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_press    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= btn;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            r_press    <= r_stable & ~r_stable_d;
            // Any return to the accepted level restarts the stability window.
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_last) begin
                r_stable <= ~r_stable;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/io_handshake.sv
`default_nettype none
// ============================================================================
// Module   : io_handshake
// Brief    : Stalls in/out instructions until a debounced confirm press.
// Revision : 1.0 - initial release
// ============================================================================
module io_handshake
    import io_pkg::*;
#(
    parameter int DATA_W          = DATA_W_DEFAULT,
    parameter int SW_W            = SW_W_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_req,
    input  logic              out_req,
    input  logic [SW_W-1:0]   sw,
    input  logic              btn,
    input  logic [DATA_W-1:0] out_data,
    output logic              flag,
    output logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid
);

    io_state_t         r_state;
    logic [DATA_W-1:0] r_in_data;
    logic [DATA_W-1:0] r_disp_data;
    logic              r_disp_valid;
    logic              w_press;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .press (w_press)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_in_data    <= '0;
            r_disp_data  <= '0;
            r_disp_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_req) begin
                        r_state <= ST_WAIT_IN;
                    end else if (out_req) begin
                        r_state      <= ST_WAIT_OUT;
                        r_disp_data  <= out_data;
                        r_disp_valid <= 1'b1;
                    end
                end
                ST_WAIT_IN: begin
                    if (!in_req) begin
                        r_state <= ST_IDLE;
                    end else if (w_press) begin
                        r_state   <= ST_RELEASE;
                        r_in_data <= DATA_W'(sw);
                    end
                end
                ST_WAIT_OUT: begin
                    if (!out_req) begin
                        r_state <= ST_IDLE;
                    end else if (w_press) begin
                        r_state <= ST_RELEASE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall must appear in the same cycle as the request so the PC holds.
    always_comb begin
        flag = 1'b0;
        case (r_state)
            ST_IDLE:     flag = in_req | out_req;
            ST_WAIT_IN:  flag = 1'b1;
            ST_WAIT_OUT: flag = 1'b1;
            default:     flag = 1'b0;
        endcase
    end

    assign in_data    = r_in_data;
    assign disp_data  = r_disp_data;
    assign disp_valid = r_disp_valid;

endmodule
`default_nettype wire

// File: tb/tb_io_handshake.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_handshake
// Brief    : Directed self-checking bench for io_handshake (debounce = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_handshake;

    logic        clk;
    logic        rst;
    logic        in_req;
    logic        out_req;
    logic [17:0] sw;
    logic        btn;
    logic [31:0] out_data;
    logic        flag;
    logic [31:0] in_data;
    logic [31:0] disp_data;
    logic        disp_valid;

    int n_checks;
    int n_fail;

    io_handshake #(
        .DATA_W          (32),
        .SW_W            (18),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_req     (in_req),
        .out_req    (out_req),
        .sw         (sw),
        .btn        (btn),
        .out_data   (out_data),
        .flag       (flag),
        .in_data    (in_data),
        .disp_data  (disp_data),
        .disp_valid (disp_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raw press accepted: 2 sync + 4 debounce edges, press one edge later,
    // RELEASE on the following edge -> flag drops after the 8th edge.
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        in_req   = 1'b0;
        out_req  = 1'b0;
        sw       = '0;
        btn      = 1'b0;
        out_data = '0;
        step(2);
        rst = 1'b0;
        #1;
        check("rst_flag", {31'd0, flag}, 32'd0);
        check("rst_in_data", in_data, 32'd0);
        check("rst_disp_data", disp_data, 32'd0);
        check("rst_disp_valid", {31'd0, disp_valid}, 32'd0);

        // in instruction
        in_req = 1'b1;
        sw     = 18'h2A5A5;
        #1;
        check("in_flag_comb", {31'd0, flag}, 32'd1);
        step(1);
        btn = 1'b1;
        step(7);
        check("in_flag_before_rel", {31'd0, flag}, 32'd1);
        check("in_data_not_yet", in_data, 32'd0);
        step(1);
        check("in_flag_release", {31'd0, flag}, 32'd0);
        check("in_data_capt", in_data, 32'h0002A5A5);
        in_req = 1'b0;
        btn    = 1'b0;
        step(1);
        check("in_back_idle", {31'd0, flag}, 32'd0);
        step(10);

        // out instruction
        out_req  = 1'b1;
        out_data = 32'hDEADBEEF;
        #1;
        check("out_flag_comb", {31'd0, flag}, 32'd1);
        check("out_valid_pre", {31'd0, disp_valid}, 32'd0);
        step(1);
        check("out_disp_data", disp_data, 32'hDEADBEEF);
        check("out_disp_valid", {31'd0, disp_valid}, 32'd1);
        check("out_flag_wait", {31'd0, flag}, 32'd1);
        btn = 1'b1;
        step(7);
        check("out_flag_before_rel", {31'd0, flag}, 32'd1);
        step(1);
        check("out_flag_release", {31'd0, flag}, 32'd0);
        out_req  = 1'b0;
        out_data = 32'h0;
        btn      = 1'b0;
        step(1);
        check("out_idle_flag", {31'd0, flag}, 32'd0);
        check("out_disp_hold", disp_data, 32'hDEADBEEF);
        step(10);

        // glitches then one 6-cycle press
        in_req = 1'b1;
        sw     = 18'h00001;
        step(1);
        for (int g = 1; g <= 3; g++) begin
            btn = 1'b1;
            step(g);
            btn = 1'b0;
            step(6);
            check($sformatf("glitch%0d_flag", g), {31'd0, flag}, 32'd1);
            check($sformatf("glitch%0d_data", g), in_data, 32'h0002A5A5);
        end
        btn = 1'b1;
        step(6);
        btn = 1'b0;
        step(1);
        check("long_flag_pre", {31'd0, flag}, 32'd1);
        step(1);
        check("long_flag_release", {31'd0, flag}, 32'd0);
        check("long_in_data", in_data, 32'h00000001);
        step(1);
        check("long_back2back", {31'd0, flag}, 32'd1);
        step(10);
        check("long_single_rel", {31'd0, flag}, 32'd1);
        check("long_data_hold", in_data, 32'h00000001);
        in_req = 1'b0;
        step(1);
        check("long_idle", {31'd0, flag}, 32'd0);
        step(4);

        // button held across two in instructions
        in_req = 1'b1;
        sw     = 18'h00003;
        step(1);
        btn = 1'b1;
        step(8);
        check("held1_release", {31'd0, flag}, 32'd0);
        check("held1_data", in_data, 32'h00000003);
        sw = 18'h3FFFF;
        step(1);
        check("held2_stall", {31'd0, flag}, 32'd1);
        step(12);
        check("held2_still", {31'd0, flag}, 32'd1);
        check("held2_data_hold", in_data, 32'h00000003);
        btn = 1'b0;
        step(10);
        check("held2_after_rel", {31'd0, flag}, 32'd1);
        btn = 1'b1;
        step(7);
        check("held2_pre", {31'd0, flag}, 32'd1);
        step(1);
        check("held2_release", {31'd0, flag}, 32'd0);
        check("held2_data", in_data, 32'h0003FFFF);
        in_req = 1'b0;
        btn    = 1'b0;
        step(10);

        // both requests: in wins, display untouched
        in_req   = 1'b1;
        out_req  = 1'b1;
        sw       = 18'h15555;
        out_data = 32'h12345678;
        #1;
        check("both_flag", {31'd0, flag}, 32'd1);
        step(1);
        check("both_disp_hold", disp_data, 32'hDEADBEEF);
        out_req = 1'b0;
        btn     = 1'b1;
        step(8);
        check("both_release", {31'd0, flag}, 32'd0);
        check("both_in_data", in_data, 32'h00015555);
        check("both_disp_final", disp_data, 32'hDEADBEEF);
        in_req = 1'b0;
        btn    = 1'b0;
        step(10);

        // asynchronous reset during WAIT_OUT
        out_req  = 1'b1;
        out_data = 32'hCAFEF00D;
        step(1);
        check("rw_disp_data", disp_data, 32'hCAFEF00D);
        step(2);
        #2;
        rst = 1'b1;
        #1;
        check("rw_disp_zero", disp_data, 32'd0);
        check("rw_valid_zero", {31'd0, disp_valid}, 32'd0);
        check("rw_in_zero", in_data, 32'd0);
        check("rw_flag_req", {31'd0, flag}, 32'd1);
        out_req = 1'b0;
        #1;
        check("rw_flag_noreq", {31'd0, flag}, 32'd0);
        step(1);
        rst = 1'b0;
        step(1);
        check("rw_idle_after", {31'd0, flag}, 32'd0);
        check("rw_valid_after", {31'd0, disp_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
